// File: rtl/pulse_meter.sv
// Pulse-train meter: measures first pulse width, first spacing and pulse count
// of a synchronised input, flagging irregular trains and counter saturation.
module pulse_meter (
  input  logic        clk,
  input  logic        rst,
  input  logic        sig_i,
  input  logic        arm_i,
  input  logic [15:0] end_gap_i,
  output logic [7:0]  width_o,
  output logic [15:0] spacing_o,
  output logic [7:0]  num_pulses_o,
  output logic        mismatch_o,
  output logic        ovf_o,
  output logic        busy_o,
  output logic        done_o
);

  typedef enum logic [2:0] {IDLE, ARMED, HIGH, LOW, DONE} state_t;

  state_t      state, state_nx;
  logic        sig_p0, sig_p1, sig_p2;
  logic [7:0]  hcnt, hcnt_nx;
  logic [16:0] lcnt, lcnt_nx;
  logic [16:0] lcnt_inc, gap_lim;
  logic [15:0] gap_m1;
  logic [7:0]  width_nx, npul_nx;
  logic [15:0] spacing_nx;
  logic        mism_nx, ovf_nx;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic at_max8(input logic [7:0] v);
    return (v == 8'hFF);
  endfunction

  assign gap_lim  = {1'b0, end_gap_i} + 17'd1;
  assign lcnt_inc = lcnt + 17'd1;
  assign gap_m1   = lcnt[15:0] - 16'd1;

  // Synchroniser (p0, p1) plus one-cycle delay (p2) for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sig_p0 <= 1'b0;
      sig_p1 <= 1'b0;
      sig_p2 <= 1'b0;
    end else begin
      sig_p0 <= sig_i;
      sig_p1 <= sig_p0;
      sig_p2 <= sig_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    hcnt_nx    = hcnt;
    lcnt_nx    = lcnt;
    width_nx   = width_o;
    spacing_nx = spacing_o;
    npul_nx    = num_pulses_o;
    mism_nx    = mismatch_o;
    ovf_nx     = ovf_o;
    if (arm_i) begin
      state_nx   = ARMED;
      hcnt_nx    = 8'd0;
      lcnt_nx    = 17'd0;
      width_nx   = 8'd0;
      spacing_nx = 16'd0;
      npul_nx    = 8'd0;
      mism_nx    = 1'b0;
      ovf_nx     = 1'b0;
    end else begin
      case (state)
        ARMED: begin
          if (sig_p1 && !sig_p2) begin
            hcnt_nx  = 8'd0;
            state_nx = HIGH;
          end
        end
        HIGH: begin
          if (sig_p1) begin
            if (at_max8(hcnt)) ovf_nx = 1'b1;
            hcnt_nx = sat_inc8(hcnt);
          end else begin
            // The hcnt register already holds (high cycles - 1)
            npul_nx = sat_inc8(num_pulses_o);
            if (at_max8(num_pulses_o)) ovf_nx = 1'b1;
            if (num_pulses_o == 8'd0)  width_nx = hcnt;
            else if (hcnt != width_o)  mism_nx = 1'b1;
            lcnt_nx = 17'd1;
            if (end_gap_i == 16'd0) state_nx = DONE;
            else                    state_nx = LOW;
          end
        end
        LOW: begin
          if (sig_p1) begin
            if (num_pulses_o == 8'd1)   spacing_nx = gap_m1;
            else if (gap_m1 != spacing_o) mism_nx = 1'b1;
            hcnt_nx  = 8'd0;
            state_nx = HIGH;
          end else begin
            lcnt_nx = lcnt_inc;
            if (lcnt_inc >= gap_lim) state_nx = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt         <= 8'd0;
      lcnt         <= 17'd0;
      width_o      <= 8'd0;
      spacing_o    <= 16'd0;
      num_pulses_o <= 8'd0;
      mismatch_o   <= 1'b0;
      ovf_o        <= 1'b0;
    end else begin
      hcnt         <= hcnt_nx;
      lcnt         <= lcnt_nx;
      width_o      <= width_nx;
      spacing_o    <= spacing_nx;
      num_pulses_o <= npul_nx;
      mismatch_o   <= mism_nx;
      ovf_o        <= ovf_nx;
    end
  end

  assign busy_o = (state == ARMED) || (state == HIGH) || (state == LOW);
  assign done_o = (state == DONE);

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Measures a digital pulse train on one input pin and reports pulse width, inter-pulse spacing and pulse count. Results use the same minus-one encoding as the `pulser` configuration fields, so a measured train can be replayed directly or compared against the programmed values. The block sits on the glitcher's observation side: it self-checks the pulser output in loopback, or characterises a target's trigger and strobe lines.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; synchronous, active-high
- sig_i  in  1  asynchronous pulse input; active-high pulses
- arm_i  in  1  single-cycle start strobe; clears previous results
- end_gap_i  in  16  low run that terminates a train; a train ends after end_gap_i+1 consecutive low cycles
- width_o  out  8  high cycles of the first pulse, minus 1
- spacing_o  out  16  low cycles between pulse 1 and pulse 2, minus 1; 0 if only one pulse
- num_pulses_o  out  8  number of complete pulses, saturating at 255
- mismatch_o  out  1  a later pulse's width or spacing differed from the first
- ovf_o  out  1  the width counter or the pulse counter saturated
- busy_o  out  1  measurement in progress
- done_o  out  1  results valid; level, held until the next arm_i or rst

## Operation
- sig_i passes through a 2-FF synchroniser, giving s. Edge detection compares s with s_d, its value one cycle earlier.
- States: IDLE, ARMED, HIGH, LOW, DONE.
- IDLE/DONE, arm_i=1 -> ARMED. On the same edge, all result outputs, mismatch_o, ovf_o and done_o clear to 0.
- ARMED: waits for a rising edge (s=1, s_d=0). A level that is already high at arm time is not counted; it must fall and rise again. On the rising edge, the high counter is set to 0 and the state goes to HIGH.
- HIGH: the high counter increments each cycle while s=1 and saturates at 255. Saturation sets ovf_o.
  - On the first s=0 cycle, the pulse is complete. num_pulses_o increments, saturating at 255; if the increment is blocked at 255, ovf_o sets.
  - For pulse 1, width_o <= count of high cycles − 1. For later pulses, if the count − 1 ≠ width_o, mismatch_o sets.
  - That s=0 cycle is low cycle 1 of the gap. The state goes to LOW.
- LOW: counts consecutive low cycles L.
  - If s rises with L ≤ end_gap_i, spacing is L−1. For the first gap, spacing_o <= L−1; for later gaps, if L−1 ≠ spacing_o, mismatch_o sets. The state goes to HIGH with the high counter restarted.
  - When L reaches end_gap_i+1, the state goes to DONE and done_o=1.
  - With end_gap_i=0, every train ends after its first pulse.
- DONE: holds all outputs. sig_i is ignored.
- Arithmetic: the low counter is 17 bits wide, so L = 65536 never wraps. Outputs store L−1 and count−1, which are always ≥ 0.
- arm_i during ARMED/HIGH/LOW: the current measurement is discarded and the block restarts as from IDLE.
- rst at any time: the state returns to IDLE and every output returns to its reset value. The synchroniser flops clear to 0.

## Timing
- Reset values: width_o=0, spacing_o=0, num_pulses_o=0, mismatch_o=0, ovf_o=0, busy_o=0, done_o=0.
- busy_o=1 exactly in ARMED, HIGH and LOW. It rises the cycle after arm_i and falls the same cycle done_o rises.
- Synchroniser latency: 2 cycles from sig_i to s. Widths and spacings are unaffected.
- width_o for pulse 1 is valid 3 cycles after the first low sample of sig_i.
- done_o rises 3 cycles after the sig_i sample that completes the (end_gap_i+1)th low cycle.
- Minimum resolvable pulse: 1 cycle high and 1 cycle low. For sig_i driven synchronously from clk, measurement is cycle-exact.
- Input toggling faster than the clock is undefined, with no metastability propagation beyond the synchroniser.

## Test plan
- **Regular train:** 3 pulses, 5 cycles high and 10 cycles low, end_gap_i=100 -> width_o=4, spacing_o=9, num_pulses_o=3, mismatch_o=0, ovf_o=0, done_o=1. Also run in loopback with pulser (width 4, spacing 9, 3 pulses) and require identical values.
- **Single 1-cycle pulse:** end_gap_i=0 -> width_o=0, spacing_o=0, num_pulses_o=1.
- **Irregular train:** widths 5 then 6, both spacings 10 -> width_o=4, mismatch_o=1. Repeat with equal widths and spacings 10 then 8 -> spacing_o=9, mismatch_o=1.
- **Gap boundary:** end_gap_i=9, two pulses separated by 9 low cycles -> num_pulses_o=2, spacing_o=8. Separated by 10 low cycles -> num_pulses_o=1, done_o rises before the second pulse.
- **Saturation and arm timing:** sig_i already high at arm_i, then 300 pulses of 2 high / 2 low -> the initial high level is not counted, num_pulses_o=255, ovf_o=1. A single 400-cycle pulse -> width_o=255, ovf_o=1.
- **Reset and re-arm mid-train:** rst asserted in HIGH -> all outputs 0 next cycle and the state is IDLE. arm_i asserted in LOW -> results cleared and busy_o stays 1, then a fresh 2-pulse train is measured correctly.
